// File: rtl/hilo_mdu_ctrl_pkg.sv
// hilo_mdu_ctrl_pkg
//   Operation codes shared between the EX-stage ALU control and the
//   multiply/divide sequencer. The values match EXE_*_OP in defines.vh.
package hilo_mdu_ctrl_pkg;

   localparam logic [7:0] EXE_MULT_OP  = 8'b0001_1000;
   localparam logic [7:0] EXE_MULTU_OP = 8'b0001_1001;
   localparam logic [7:0] EXE_DIV_OP   = 8'b0001_1010;
   localparam logic [7:0] EXE_DIVU_OP  = 8'b0001_1011;
   localparam logic [7:0] EXE_MTHI_OP  = 8'b0001_0001;
   localparam logic [7:0] EXE_MTLO_OP  = 8'b0001_0011;

endpackage

// File: rtl/hilo_mdu_ctrl_if.sv
// hilo_mdu_ctrl_if
//   Bundle between the EX stage (master) and the MDU sequencer (slave).
//   EX -> MDU : start, alucontrol, src_a, src_b, flush
//   MDU -> EX : stall_o, busy
//   MDU -> HI/LO file : hi_we, lo_we, hi_wdata, lo_wdata
interface hilo_mdu_ctrl_if;
   logic        start;
   logic [7:0]  alucontrol;
   logic [31:0] src_a;
   logic [31:0] src_b;
   logic        flush;
   logic        stall_o;
   logic        hi_we;
   logic        lo_we;
   logic [31:0] hi_wdata;
   logic [31:0] lo_wdata;
   logic        busy;

   modport master (
      output start, alucontrol, src_a, src_b, flush,
      input  stall_o, hi_we, lo_we, hi_wdata, lo_wdata, busy
   );

   modport slave (
      input  start, alucontrol, src_a, src_b, flush,
      output stall_o, hi_we, lo_we, hi_wdata, lo_wdata, busy
   );
endinterface

// File: rtl/hilo_mdu_ctrl_div_iter.sv
// div_iter
//   Purely combinational helpers for the radix-2 restoring divider.
//   i_a/i_b/i_signed     -> o_abs_a/o_abs_b magnitudes, o_q_neg/o_r_neg sign flags
//   i_rq/i_dvsr          -> o_rq: one shift-subtract step on {remainder, quotient}
//   i_q_neg/i_r_neg      -> o_quo/o_rem: sign-corrected result taken from o_rq
module div_iter (
   input  logic [31:0] i_a,
   input  logic [31:0] i_b,
   input  logic        i_signed,
   output logic [31:0] o_abs_a,
   output logic [31:0] o_abs_b,
   output logic        o_q_neg,
   output logic        o_r_neg,
   input  logic [63:0] i_rq,
   input  logic [31:0] i_dvsr,
   output logic [63:0] o_rq,
   input  logic        i_q_neg,
   input  logic        i_r_neg,
   output logic [31:0] o_quo,
   output logic [31:0] o_rem
);

   logic [64:0] w_sh;
   logic [32:0] w_top;
   logic        w_ge;
   logic [31:0] w_rem_new;

   assign o_abs_a = (i_signed && i_a[31]) ? -i_a : i_a;
   assign o_abs_b = (i_signed && i_b[31]) ? -i_b : i_b;
   // Quotient negative when signs differ; remainder follows the dividend.
   assign o_q_neg = i_signed && (i_a[31] ^ i_b[31]);
   assign o_r_neg = i_signed && i_a[31];

   // The shifted partial remainder can need 33 bits, so keep the carry-out.
   assign w_sh      = {i_rq, 1'b0};
   assign w_top     = w_sh[64:32];
   assign w_ge      = (w_top >= {1'b0, i_dvsr});
   // When w_ge holds the difference is below the divisor, so 32 bits suffice.
   assign w_rem_new = w_top[31:0] - i_dvsr;
   assign o_rq      = w_ge ? {w_rem_new, w_sh[31:1], 1'b1} : w_sh[63:0];

   assign o_quo = i_q_neg ? -o_rq[31:0]  : o_rq[31:0];
   assign o_rem = i_r_neg ? -o_rq[63:32] : o_rq[63:32];

endmodule

// File: rtl/hilo_mdu_ctrl.sv
// hilo_mdu_ctrl
//   Sequencer for the multi-cycle multiply/divide unit that writes HI/LO.
//   clk : system clock
//   rst : synchronous active-high reset
//   bus : hilo_mdu_ctrl_if.slave (operation request, stall/busy, HI/LO writes)
//   MULT/MULTU run MUL_LAT cycles, DIV/DIVU run DIV_ITERS restoring steps,
//   then DONE raises both write strobes for one cycle. MTHI/MTLO write
//   straight through in IDLE without stalling.
module hilo_mdu_ctrl
   import hilo_mdu_ctrl_pkg::*;
#(
   parameter int MUL_LAT   = 2,
   parameter int DIV_ITERS = 32
) (
   input  logic            clk,
   input  logic            rst,
   hilo_mdu_ctrl_if.slave  bus
);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_MUL_RUN = 2'd1;
   localparam logic [1:0] S_DIV_RUN = 2'd2;
   localparam logic [1:0] S_DONE    = 2'd3;

   localparam int CMAX = (MUL_LAT > DIV_ITERS) ? MUL_LAT : DIV_ITERS;
   localparam int CW   = $clog2(CMAX + 1);

   logic [1:0]    r_state, w_next;
   logic [CW-1:0] r_cnt;
   logic [31:0]   r_ma, r_mb;
   logic          r_msigned;
   logic [63:0]   r_rq;
   logic [31:0]   r_dvsr;
   logic          r_qneg, r_rneg;
   logic [31:0]   r_hi, r_lo;

   logic          w_is_mul, w_is_div, w_div0, w_mthi, w_mtlo, w_signed;
   logic [63:0]   w_ea, w_eb, w_prod;
   logic [31:0]   w_abs_a, w_abs_b, w_quo, w_rem;
   logic          w_q_neg, w_r_neg;
   logic [63:0]   w_rq_next;
   logic          w_cnt_zero;

   // ---- decode (meaningful only in IDLE) ----
   assign w_is_mul = bus.start && (bus.alucontrol == EXE_MULT_OP  ||
                                   bus.alucontrol == EXE_MULTU_OP);
   assign w_is_div = bus.start && (bus.alucontrol == EXE_DIV_OP   ||
                                   bus.alucontrol == EXE_DIVU_OP);
   assign w_div0   = w_is_div && (bus.src_b == 32'd0);
   assign w_mthi   = bus.start && (bus.alucontrol == EXE_MTHI_OP);
   assign w_mtlo   = bus.start && (bus.alucontrol == EXE_MTLO_OP);
   assign w_signed = (bus.alucontrol == EXE_MULT_OP) ||
                     (bus.alucontrol == EXE_DIV_OP);
   assign w_cnt_zero = (r_cnt == '0);

   // Low 64 bits of the product of extended operands give both the
   // signed and unsigned 64-bit results.
   assign w_ea   = r_msigned ? {{32{r_ma[31]}}, r_ma} : {32'd0, r_ma};
   assign w_eb   = r_msigned ? {{32{r_mb[31]}}, r_mb} : {32'd0, r_mb};
   assign w_prod = w_ea * w_eb;

   div_iter u_div_iter (
      .i_a      (bus.src_a),
      .i_b      (bus.src_b),
      .i_signed (w_signed),
      .o_abs_a  (w_abs_a),
      .o_abs_b  (w_abs_b),
      .o_q_neg  (w_q_neg),
      .o_r_neg  (w_r_neg),
      .i_rq     (r_rq),
      .i_dvsr   (r_dvsr),
      .o_rq     (w_rq_next),
      .i_q_neg  (r_qneg),
      .i_r_neg  (r_rneg),
      .o_quo    (w_quo),
      .o_rem    (w_rem)
   );

   // ---- FSM: state register ----
   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   // ---- FSM: next state ----
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_is_mul)      w_next = S_MUL_RUN;
            else if (w_div0)   w_next = S_DONE;
            else if (w_is_div) w_next = S_DIV_RUN;
         end
         S_MUL_RUN: if (w_cnt_zero) w_next = S_DONE;
         S_DIV_RUN: if (w_cnt_zero) w_next = S_DONE;
         default:   w_next = S_IDLE;
      endcase
      if (bus.flush) w_next = S_IDLE;
   end

   // ---- FSM: outputs ----
   always_comb begin
      bus.stall_o  = 1'b0;
      bus.hi_we    = 1'b0;
      bus.lo_we    = 1'b0;
      bus.hi_wdata = r_hi;
      bus.lo_wdata = r_lo;
      if (!rst && !bus.flush) begin
         case (r_state)
            S_IDLE: begin
               bus.stall_o = w_is_mul || w_is_div;
               bus.hi_we   = w_mthi;
               bus.lo_we   = w_mtlo;
               if (w_mthi) bus.hi_wdata = bus.src_a;
               if (w_mtlo) bus.lo_wdata = bus.src_a;
            end
            S_MUL_RUN, S_DIV_RUN: bus.stall_o = 1'b1;
            default: begin
               bus.hi_we = 1'b1;
               bus.lo_we = 1'b1;
            end
         endcase
      end
   end

   assign bus.busy = (r_state != S_IDLE);

   // ---- datapath: operand latches, counter, result registers ----
   // Results land in r_hi/r_lo on the transition into DONE so they are
   // stable for the whole strobe cycle and held afterwards.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt     <= '0;
         r_ma      <= '0;
         r_mb      <= '0;
         r_msigned <= 1'b0;
         r_rq      <= '0;
         r_dvsr    <= '0;
         r_qneg    <= 1'b0;
         r_rneg    <= 1'b0;
         r_hi      <= '0;
         r_lo      <= '0;
      end else if (!bus.flush) begin
         case (r_state)
            S_IDLE: begin
               if (w_is_mul) begin
                  r_ma      <= bus.src_a;
                  r_mb      <= bus.src_b;
                  r_msigned <= w_signed;
                  r_cnt     <= CW'(MUL_LAT - 1);
               end else if (w_div0) begin
                  r_hi <= bus.src_a;
                  r_lo <= 32'hFFFF_FFFF;
               end else if (w_is_div) begin
                  r_rq   <= {32'd0, w_abs_a};
                  r_dvsr <= w_abs_b;
                  r_qneg <= w_q_neg;
                  r_rneg <= w_r_neg;
                  r_cnt  <= CW'(DIV_ITERS - 1);
               end
               if (w_mthi) r_hi <= bus.src_a;
               if (w_mtlo) r_lo <= bus.src_a;
            end
            S_MUL_RUN: begin
               if (w_cnt_zero) begin
                  r_hi <= w_prod[63:32];
                  r_lo <= w_prod[31:0];
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            S_DIV_RUN: begin
               r_rq <= w_rq_next;
               if (w_cnt_zero) begin
                  r_hi <= w_rem;
                  r_lo <= w_quo;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
